controlador_principal: RTL and testbench
========================================

Name: controlador_principal

Overview:
Main controller of the FPGA Tamagotchi. It runs the pet's activity state machine from two push-buttons and keeps three 8-bit wellbeing meters: fome (satiety), sono (rest) and felicidade (happiness). The meters decay once per second and the current activity refills one of them. The block drives the state code and meter values to the display and output logic.

Parameters:
TICKS_PER_SEC, 100, clk cycles per one-second tick (100 Hz clock)
MAX_VAL, 100, upper saturation value of every meter
INIT_VAL, 100, meter value after reset
DECAY, 1, amount subtracted per tick from every meter that is not being refilled
GAIN, 5, amount added per tick to the meter being refilled

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  reset, asynchronous, active-low
b1  in  1  button 1, active-high, synchronous to clk
b2  in  1  button 2, active-high, synchronous to clk
estado  out  3  pet state code
fome  out  8  satiety meter, 0..MAX_VAL
felicidade  out  8  happiness meter, 0..MAX_VAL
sono  out  8  rest meter, 0..MAX_VAL

Behaviour:
- One clock domain. Reset is asynchronous and active-low (rst_n); clock is clk.
- Reset values: estado=IDLE (000); fome=sono=felicidade=INIT_VAL; tick counter=0; button history=0.
- State codes: IDLE=000, COMENDO=001, DORMINDO=010, DANDO_AULA=011, MORTO=100. Codes 101-111 are unreachable and recover to IDLE on the next clock.
- Press event: registered prev={b1,b2}. An event fires when prev==00 and the current {b1,b2}!=00. The event code is the current {b1,b2}. A press held for several cycles counts once. A button that is released and pressed again counts again.
- Transitions take effect on the clock edge that samples the event, so estado updates 1 cycle after the press:
  IDLE: 10 -> COMENDO, 01 -> DORMINDO, 11 -> DANDO_AULA.
  COMENDO: 10 -> IDLE. DORMINDO: 01 -> IDLE. DANDO_AULA: 11 -> IDLE.
  Any other code in a non-IDLE state is ignored.
  MORTO is absorbing. All buttons are ignored and only rst_n leaves it.
- Tick: a free-running counter runs 0..TICKS_PER_SEC-1 and asserts tick for one cycle at wrap. State changes do not reset the counter. It stops counting in MORTO.
- On a tick cycle, when not in MORTO:
  The refilled meter gets min(MAX_VAL, v+GAIN). COMENDO refills fome, DORMINDO refills sono, DANDO_AULA refills felicidade. IDLE refills none.
  Every other meter gets v-DECAY, floored at 0. There is no wrap in either direction.
  The refill choice uses the state present before the edge.
- Death: at any edge where a meter is 0 (registered value) and the state is not MORTO, estado becomes MORTO.
  Death has priority over a simultaneous button event.
  Meters freeze in MORTO.
- Outputs are registered directly. There is no combinational path from the buttons to the outputs.
- rst_n asserted mid-operation, including in MORTO, immediately restores the reset values.

Decomposition:
- Shared package: the state-code constants (IDLE, COMENDO, DORMINDO, DANDO_AULA, MORTO), the 3-bit state typedef, and the defaults of MAX_VAL, INIT_VAL, DECAY and GAIN.
- One sub-module: tick_gen (parameter TICKS_PER_SEC; clk, rst_n, enable in; tick out).
- The FSM, meter saturating arithmetic and edge detection stay in the top module.

Test Plan:
1. Reset, then 3 s with no buttons -> estado=000, fome=sono=felicidade=97.
2. From 1, pulse b1 for one cycle -> estado=001 one cycle later. After 3 more s: fome=100 (saturated), sono=felicidade=94. Pulse b1 again -> estado=000.
3. From IDLE, pulse b2 -> estado=010. Each second sono rises by 5 (saturating at 100) while fome and felicidade fall by 1. Pulse b2 -> 000.
4. From IDLE, pulse b1&b2 together -> estado=011 and felicidade rises 5/s. In 011, b1 alone or b2 alone -> no change. Pulse b1&b2 -> 000.
5. Hold b1 high 50 cycles in IDLE -> exactly one transition (000->001) and no toggle back.
6. IDLE with no buttons from the meters at 100 -> after 100 s a meter reaches 0 and estado=100 on the next edge. Further presses -> estado stays 100 and meters stay frozen. Then assert rst_n=0 -> estado=000 and meters=100 immediately.

Source files
------------

// File: rtl/controlador_principal_pkg.sv
// Shared definitions for the Tamagotchi main controller: state codes,
// default meter parameters and saturating meter arithmetic.
package controlador_principal_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'b000,
      COMENDO    = 3'b001,
      DORMINDO   = 3'b010,
      DANDO_AULA = 3'b011,
      MORTO      = 3'b100
   } estado_t;

   localparam int MAX_VAL_DEF  = 100;
   localparam int INIT_VAL_DEF = 100;
   localparam int DECAY_DEF    = 1;
   localparam int GAIN_DEF     = 5;

   localparam int NUM_METERS = 3;
   localparam int FOME_IDX   = 0;
   localparam int SONO_IDX   = 1;
   localparam int FELI_IDX   = 2;

   // Sums are done in int so v+amt can never wrap before the clamp.
   function automatic logic [7:0] sat_add(input logic [7:0] v, input int amt, input int maxv);
      int s;
      s = int'(v) + amt;
      return (s > maxv) ? 8'(maxv) : 8'(s);
   endfunction

   function automatic logic [7:0] sat_sub(input logic [7:0] v, input int amt);
      int s;
      s = int'(v) - amt;
      return (s < 0) ? 8'd0 : 8'(s);
   endfunction

endpackage

// File: rtl/controlador_principal_tick_gen.sv
// One-second tick generator: free-running modulo-TICKS_PER_SEC counter that
// pulses tick for one cycle at wrap and holds its count while disabled.
module tick_gen #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tick
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (enable) begin
         cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign tick = enable && (cnt_reg == LAST);

endmodule

// File: rtl/controlador_principal.sv
// Tamagotchi main controller: activity FSM driven by two buttons, plus three
// saturating wellbeing meters that decay or refill once per second.
module controlador_principal
   import controlador_principal_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100,
   parameter int MAX_VAL       = MAX_VAL_DEF,
   parameter int INIT_VAL      = INIT_VAL_DEF,
   parameter int DECAY         = DECAY_DEF,
   parameter int GAIN          = GAIN_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       b1,
   input  logic       b2,
   output logic [2:0] estado,
   output logic [7:0] fome,
   output logic [7:0] felicidade,
   output logic [7:0] sono
);

   estado_t state_reg;
   estado_t state_next;

   logic [1:0] btn_prev_reg;
   logic [1:0] btn_cur;
   logic       press_event;

   logic                       tick;
   logic                       alive;
   logic [NUM_METERS-1:0]      refill_sel;
   logic [NUM_METERS-1:0]      meter_zero;
   logic [NUM_METERS-1:0][7:0] meter_val;

   // A press is the first non-idle button pattern after both were released.
   assign btn_cur     = {b1, b2};
   assign press_event = (btn_prev_reg == 2'b00) && (btn_cur != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev_reg <= 2'b00;
      end else begin
         btn_prev_reg <= btn_cur;
      end
   end

   tick_gen #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .enable(alive),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // An empty meter outranks any button event on the same edge.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (|meter_zero) begin
               state_next = MORTO;
            end else if (press_event) begin
               case (btn_cur)
                  2'b10:   state_next = COMENDO;
                  2'b01:   state_next = DORMINDO;
                  2'b11:   state_next = DANDO_AULA;
                  default: state_next = IDLE;
               endcase
            end
         end
         COMENDO: begin
            if (|meter_zero) begin
               state_next = MORTO;
            end else if (press_event && btn_cur == 2'b10) begin
               state_next = IDLE;
            end
         end
         DORMINDO: begin
            if (|meter_zero) begin
               state_next = MORTO;
            end else if (press_event && btn_cur == 2'b01) begin
               state_next = IDLE;
            end
         end
         DANDO_AULA: begin
            if (|meter_zero) begin
               state_next = MORTO;
            end else if (press_event && btn_cur == 2'b11) begin
               state_next = IDLE;
            end
         end
         MORTO:   state_next = MORTO;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      refill_sel = '0;
      alive      = 1'b1;
      case (state_reg)
         COMENDO:    refill_sel[FOME_IDX] = 1'b1;
         DORMINDO:   refill_sel[SONO_IDX] = 1'b1;
         DANDO_AULA: refill_sel[FELI_IDX] = 1'b1;
         MORTO:      alive                = 1'b0;
         default:    refill_sel           = '0;
      endcase
   end

   // Tick is already suppressed in MORTO, which is what freezes the meters.
   for (genvar gi = 0; gi < NUM_METERS; gi++) begin : g_meter
      logic [7:0] val_reg;
      logic [7:0] val_next;

      always_comb begin
         val_next = val_reg;
         if (tick) begin
            val_next = refill_sel[gi] ? sat_add(val_reg, GAIN, MAX_VAL)
                                      : sat_sub(val_reg, DECAY);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            val_reg <= 8'(INIT_VAL);
         end else begin
            val_reg <= val_next;
         end
      end

      assign meter_val[gi]  = val_reg;
      assign meter_zero[gi] = (val_reg == 8'd0);
   end

   assign estado     = state_reg;
   assign fome       = meter_val[FOME_IDX];
   assign sono       = meter_val[SONO_IDX];
   assign felicidade = meter_val[FELI_IDX];

endmodule

// File: tb/tb_controlador_principal.sv
// Self-checking bench for controlador_principal: directed scenarios plus
// random button traffic, compared against a behavioural model of the pet.
module tb_controlador_principal;

   localparam int TPS   = 100;
   localparam int MAXV  = 100;
   localparam int INITV = 100;
   localparam int DEC   = 1;
   localparam int GN    = 5;

   logic       clk;
   logic       rst_n;
   logic       b1;
   logic       b2;
   logic [2:0] estado;
   logic [7:0] fome;
   logic [7:0] felicidade;
   logic [7:0] sono;

   int n_cmp = 0;
   int n_err = 0;

   // Model: state as plain code 0..4, meters as ints {fome, sono, felicidade}.
   int         m_state;
   int         m_met[3];
   int         m_cnt;
   logic [1:0] m_prev;

   controlador_principal dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .b1        (b1),
      .b2        (b2),
      .estado    (estado),
      .fome      (fome),
      .felicidade(felicidade),
      .sono      (sono)
   );

   always #5 clk = ~clk;

   function automatic logic [26:0] dut_vec();
      return {estado, fome, sono, felicidade};
   endfunction

   function automatic logic [26:0] model_vec();
      return {3'(m_state), 8'(m_met[0]), 8'(m_met[1]), 8'(m_met[2])};
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_cnt   = 0;
      m_prev  = 2'b00;
      for (int i = 0; i < 3; i++) m_met[i] = INITV;
   endtask

   task automatic model_edge(input logic [1:0] cur);
      bit ev;
      bit tk;
      int ns;
      ev = (m_prev == 2'b00) && (cur != 2'b00);
      tk = (m_state != 4) && (m_cnt == TPS - 1);
      ns = m_state;
      if (m_state != 4) begin
         if (m_met[0] == 0 || m_met[1] == 0 || m_met[2] == 0) ns = 4;
         else if (ev) begin
            if (m_state == 0) ns = (cur == 2'b10) ? 1 : (cur == 2'b01) ? 2 : 3;
            else if ((m_state == 1 && cur == 2'b10) || (m_state == 2 && cur == 2'b01) ||
                     (m_state == 3 && cur == 2'b11)) ns = 0;
         end
      end
      if (tk) begin
         for (int i = 0; i < 3; i++) begin
            if (i == m_state - 1) m_met[i] = (m_met[i] + GN > MAXV) ? MAXV : m_met[i] + GN;
            else                  m_met[i] = (m_met[i] - DEC < 0) ? 0 : m_met[i] - DEC;
         end
      end
      if (m_state != 4) m_cnt = (m_cnt == TPS - 1) ? 0 : m_cnt + 1;
      m_prev  = cur;
      m_state = ns;
   endtask

   task automatic step(input logic bb1, input logic bb2);
      b1 = bb1;
      b2 = bb2;
      @(posedge clk);
      model_edge({bb1, bb2});
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      @(posedge clk);
      #1;
      n_cmp++;
      if (dut_vec() !== {3'd0, 8'd100, 8'd100, 8'd100}) begin
         n_err++;
         $display("FAIL reset_state: got %h required %h", dut_vec(), {3'd0, 8'd100, 8'd100, 8'd100});
      end
      #2 rst_n = 1'b1;
      $display("test_reset: estado=%0d fome=%0d sono=%0d felicidade=%0d", estado, fome, sono, felicidade);
   endtask

   task automatic test_idle_decay();
      for (int i = 0; i < 3 * TPS; i++) step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== {3'd0, 8'd97, 8'd97, 8'd97}) begin
         n_err++;
         $display("FAIL idle_3s: got %h required %h", dut_vec(), {3'd0, 8'd97, 8'd97, 8'd97});
      end
      $display("test_idle_decay: fome=%0d sono=%0d felicidade=%0d", fome, sono, felicidade);
   endtask

   task automatic test_comendo();
      b1 = 1'b1;
      b2 = 1'b0;
      #1;
      n_cmp++;
      if (estado !== 3'd0) begin
         n_err++;
         $display("FAIL comb_path: got estado %0d required 0", estado);
      end
      @(posedge clk);
      model_edge(2'b10);
      #1;
      n_cmp++;
      if (estado !== 3'd1) begin
         n_err++;
         $display("FAIL enter_comendo: got estado %0d required 1", estado);
      end
      for (int i = 0; i < 3 * TPS - 1; i++) step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== {3'd1, 8'd100, 8'd94, 8'd94}) begin
         n_err++;
         $display("FAIL comendo_3s: got %h required %h", dut_vec(), {3'd1, 8'd100, 8'd94, 8'd94});
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== model_vec() || estado !== 3'd0) begin
         n_err++;
         $display("FAIL exit_comendo: got %h required %h", dut_vec(), model_vec());
      end
      $display("test_comendo: estado=%0d fome=%0d sono=%0d felicidade=%0d", estado, fome, sono, felicidade);
   endtask

   task automatic test_dormindo();
      step(1'b0, 1'b1);
      n_cmp++;
      if (estado !== 3'd2) begin
         n_err++;
         $display("FAIL enter_dormindo: got estado %0d required 2", estado);
      end
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < TPS; i++) step(1'b0, 1'b0);
         n_cmp++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL dormindo_sec%0d: got %h required %h", s, dut_vec(), model_vec());
         end
      end
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== model_vec() || estado !== 3'd0) begin
         n_err++;
         $display("FAIL exit_dormindo: got %h required %h", dut_vec(), model_vec());
      end
      $display("test_dormindo: estado=%0d fome=%0d sono=%0d felicidade=%0d", estado, fome, sono, felicidade);
   endtask

   task automatic test_dando_aula();
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      n_cmp++;
      if (estado !== 3'd3) begin
         n_err++;
         $display("FAIL enter_aula: got estado %0d required 3", estado);
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      n_cmp++;
      if (estado !== 3'd3) begin
         n_err++;
         $display("FAIL aula_ignores_single: got estado %0d required 3", estado);
      end
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < TPS; i++) step(1'b0, 1'b0);
         n_cmp++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL aula_sec%0d: got %h required %h", s, dut_vec(), model_vec());
         end
      end
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== model_vec() || estado !== 3'd0) begin
         n_err++;
         $display("FAIL exit_aula: got %h required %h", dut_vec(), model_vec());
      end
      $display("test_dando_aula: estado=%0d fome=%0d sono=%0d felicidade=%0d", estado, fome, sono, felicidade);
   endtask

   task automatic test_hold();
      for (int i = 0; i < 50; i++) begin
         step(1'b1, 1'b0);
         n_cmp++;
         if (estado !== 3'd1) begin
            n_err++;
            $display("FAIL hold_cycle%0d: got estado %0d required 1", i, estado);
         end
      end
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== model_vec() || estado !== 3'd0) begin
         n_err++;
         $display("FAIL hold_release: got %h required %h", dut_vec(), model_vec());
      end
      $display("test_hold: estado=%0d after 50-cycle hold and re-press", estado);
   endtask

   task automatic test_random();
      logic [1:0] cur;
      int         hold_left;
      int         bad;
      cur       = 2'b00;
      hold_left = 0;
      bad       = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold_left > 0) begin
            hold_left--;
         end else if ($urandom_range(0, 7) == 0) begin
            cur       = 2'($urandom_range(1, 3));
            hold_left = $urandom_range(0, 3);
         end else begin
            cur = 2'b00;
         end
         step(cur[1], cur[0]);
         n_cmp++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            bad++;
            if (bad <= 10)
               $display("FAIL random_cycle%0d: got %h required %h", i, dut_vec(), model_vec());
         end
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (dut_vec() !== {3'd0, 8'd100, 8'd100, 8'd100}) begin
         n_err++;
         $display("FAIL midop_reset: got %h required %h", dut_vec(), {3'd0, 8'd100, 8'd100, 8'd100});
      end
      #1 rst_n = 1'b1;
      $display("test_random: 3000 cycles, estado=%0d before final reset", m_state);
   endtask

   task automatic test_morto();
      for (int i = 0; i < 100 * TPS; i++) step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== {3'd0, 8'd0, 8'd0, 8'd0}) begin
         n_err++;
         $display("FAIL meters_empty: got %h required %h", dut_vec(), {3'd0, 8'd0, 8'd0, 8'd0});
      end
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== {3'd4, 8'd0, 8'd0, 8'd0}) begin
         n_err++;
         $display("FAIL death: got %h required %h", dut_vec(), {3'd4, 8'd0, 8'd0, 8'd0});
      end
      for (int k = 1; k <= 3; k++) begin
         step(1'(k >> 1), 1'(k & 1));
         step(1'b0, 1'b0);
      end
      for (int i = 0; i < 2 * TPS; i++) step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== {3'd4, 8'd0, 8'd0, 8'd0} || dut_vec() !== model_vec()) begin
         n_err++;
         $display("FAIL morto_frozen: got %h required %h", dut_vec(), {3'd4, 8'd0, 8'd0, 8'd0});
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (dut_vec() !== {3'd0, 8'd100, 8'd100, 8'd100}) begin
         n_err++;
         $display("FAIL morto_reset: got %h required %h", dut_vec(), {3'd0, 8'd100, 8'd100, 8'd100});
      end
      #1 rst_n = 1'b1;
      step(1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== model_vec()) begin
         n_err++;
         $display("FAIL after_reset: got %h required %h", dut_vec(), model_vec());
      end
      $display("test_morto: death after 100 s, frozen, reset restores estado=%0d", estado);
   endtask

   initial begin
      clk   = 1'b0;
      rst_n = 1'b0;
      b1    = 1'b0;
      b2    = 1'b0;
      test_reset();
      test_idle_decay();
      test_comendo();
      test_dormindo();
      test_dando_aula();
      test_hold();
      test_random();
      test_morto();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
